pe_set_scheduler: RTL

- Sequences one PE set, a group of NUM_PE processing elements that share a start and stall, through a multi-pass layer computation.
- Latches the layer shape via a valid/ready config handshake and drives it as a stable broadcast to every PE controller.
- Per pass: requests a spad load, pulses a common start, and waits until every PE has gone busy and then idle.
- Sits between the top-level layer sequencer and the PE array.

---
 rtl/pe_pkg.sv | 31 +++
 rtl/pe_busy_monitor.sv | 56 +++++
 rtl/pe_set_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Types and shape-field widths shared by the PE set scheduler and the PE controllers.
package pe_pkg;

    localparam int unsigned S_WIDTH = 4;
    localparam int unsigned F_WIDTH = 6;
    localparam int unsigned U_WIDTH = 3;
    localparam int unsigned n_WIDTH = 3;
    localparam int unsigned p_WIDTH = 5;
    localparam int unsigned q_WIDTH = 3;
    localparam int unsigned V_WIDTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_ARM   = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic [S_WIDTH-1:0] S;
        logic [F_WIDTH-1:0] F;
        logic [U_WIDTH-1:0] U;
        logic [n_WIDTH-1:0] n;
        logic [p_WIDTH-1:0] p;
        logic [q_WIDTH-1:0] q;
        logic [V_WIDTH-1:0] V;
    } pe_shape_t;

endpackage

// File: rtl/pe_busy_monitor.sv
// Registered all-busy / all-idle reductions over the PE busy flags.
// With PE_SCHED_TIMEOUT_EN defined it also holds the ARM/RUN watchdog counter.
module pe_busy_monitor #(
    parameter int unsigned NUM_PE = 12
`ifdef PE_SCHED_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_PE-1:0] pe_busy_i,
    output logic              all_busy_o,
    output logic              all_idle_o
`ifdef PE_SCHED_TIMEOUT_EN
    , input  logic            wd_clr_i,
    input  logic              wd_en_i,
    output logic              wd_expired_c
`endif
);

    logic all_busy_q;
    logic all_idle_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            all_busy_q <= 1'b0;
            all_idle_q <= 1'b0;
        end else begin
            all_busy_q <= &pe_busy_i;
            all_idle_q <= ~|pe_busy_i;
        end
    end

    assign all_busy_o = all_busy_q;
    assign all_idle_o = all_idle_q;

`ifdef PE_SCHED_TIMEOUT_EN
    localparam int unsigned WD_WIDTH = 16;

    logic [WD_WIDTH-1:0] wd_cnt_q;

    // Counts cycles spent in ARM/RUN; cleared on the way into ARM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else if (wd_clr_i) begin
            wd_cnt_q <= '0;
        end else if (wd_en_i && !wd_expired_c) begin
            wd_cnt_q <= wd_cnt_q + WD_WIDTH'(1);
        end
    end

    assign wd_expired_c = wd_en_i && (wd_cnt_q == WD_WIDTH'(TIMEOUT_CYCLES - 1));
`endif

endmodule

// File: rtl/pe_set_scheduler.sv
// Sequences one PE set through a multi-pass layer: config latch, spad load, start, busy wait.
// Optional watchdog enabled by defining PE_SCHED_TIMEOUT_EN.
module pe_set_scheduler
    import pe_pkg::*;
#(
    parameter int unsigned NUM_PE     = 12,
    parameter int unsigned PASS_WIDTH = 8
`ifdef PE_SCHED_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [PASS_WIDTH-1:0] cfg_passes,
    input  logic [S_WIDTH-1:0]    cfg_S,
    input  logic [F_WIDTH-1:0]    cfg_F,
    input  logic [U_WIDTH-1:0]    cfg_U,
    input  logic [n_WIDTH-1:0]    cfg_n,
    input  logic [p_WIDTH-1:0]    cfg_p,
    input  logic [q_WIDTH-1:0]    cfg_q,
    input  logic [V_WIDTH-1:0]    cfg_V,
    output logic [S_WIDTH-1:0]    S,
    output logic [F_WIDTH-1:0]    F,
    output logic [U_WIDTH-1:0]    U,
    output logic [n_WIDTH-1:0]    n,
    output logic [p_WIDTH-1:0]    p,
    output logic [q_WIDTH-1:0]    q,
    output logic [V_WIDTH-1:0]    V,
    output logic                  load_req,
    input  logic                  load_done,
    output logic                  pe_start,
    input  logic [NUM_PE-1:0]     pe_busy,
    input  logic                  stall_in,
    output logic                  pe_stall,
    output logic [PASS_WIDTH-1:0] pass_idx,
    output logic                  sched_busy,
    output logic                  done
`ifdef PE_SCHED_TIMEOUT_EN
    , output logic                timeout_err
`endif
);

    sched_state_t          state_q, state_d;
    logic [PASS_WIDTH-1:0] pass_idx_q, pass_idx_d;
    logic [PASS_WIDTH-1:0] limit_q, limit_d;
    pe_shape_t             shape_q, shape_d;
    logic                  all_busy;
    logic                  all_idle;
    logic                  active;

    assign active = (state_q == ST_ARM) || (state_q == ST_RUN);

`ifdef PE_SCHED_TIMEOUT_EN
    logic timeout_q, timeout_d;
    logic wd_expired;

    pe_busy_monitor #(
        .NUM_PE        (NUM_PE),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_busy_mon (
        .clk         (clk),
        .reset       (reset),
        .pe_busy_i   (pe_busy),
        .all_busy_o  (all_busy),
        .all_idle_o  (all_idle),
        .wd_clr_i    (state_q == ST_ISSUE),
        .wd_en_i     (active),
        .wd_expired_c(wd_expired)
    );
`else
    pe_busy_monitor #(
        .NUM_PE(NUM_PE)
    ) u_busy_mon (
        .clk       (clk),
        .reset     (reset),
        .pe_busy_i (pe_busy),
        .all_busy_o(all_busy),
        .all_idle_o(all_idle)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pass_idx_q <= '0;
            limit_q    <= '0;
            shape_q    <= '0;
`ifdef PE_SCHED_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pass_idx_q <= pass_idx_d;
            limit_q    <= limit_d;
            shape_q    <= shape_d;
`ifdef PE_SCHED_TIMEOUT_EN
            timeout_q  <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pass_idx_d = pass_idx_q;
        limit_d    = limit_q;
        shape_d    = shape_q;
`ifdef PE_SCHED_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    shape_d.S  = cfg_S;
                    shape_d.F  = cfg_F;
                    shape_d.U  = cfg_U;
                    shape_d.n  = cfg_n;
                    shape_d.p  = cfg_p;
                    shape_d.q  = cfg_q;
                    shape_d.V  = cfg_V;
                    limit_d    = (cfg_passes == '0) ? PASS_WIDTH'(1) : cfg_passes;
                    pass_idx_d = '0;
`ifdef PE_SCHED_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_done) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_ARM;
            end
            // Absorbs the PE controllers' start-to-busy latency before idle is trusted.
            ST_ARM: begin
                if (all_busy) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (all_idle) begin
                    if (pass_idx_q == limit_q - PASS_WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        pass_idx_d = pass_idx_q + PASS_WIDTH'(1);
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef PE_SCHED_TIMEOUT_EN
        if (active && wd_expired) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
        end
`endif
    end

    assign cfg_ready  = (state_q == ST_IDLE);
    assign load_req   = (state_q == ST_LOAD);
    assign pe_start   = (state_q == ST_ISSUE);
    assign done       = (state_q == ST_DONE);
    assign sched_busy = (state_q != ST_IDLE);
    assign pe_stall   = stall_in && active;
    assign pass_idx   = pass_idx_q;
    assign S          = shape_q.S;
    assign F          = shape_q.F;
    assign U          = shape_q.U;
    assign n          = shape_q.n;
    assign p          = shape_q.p;
    assign q          = shape_q.q;
    assign V          = shape_q.V;
`ifdef PE_SCHED_TIMEOUT_EN
    assign timeout_err = timeout_q;
`endif

endmodule
